pixel_write_buffer: RTL and testbench



---
 rtl/pixel_write_buffer.sv | 162 ++++++++++++++++
 tb/tb_pixel_write_buffer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_write_buffer.sv
// Pixel write buffer: queues in-range draw-bus pixels and replays them as frame-buffer writes,
// one write held on the memory port until fb_ready accepts it.
module pixel_write_buffer #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vga_draw_enable_bus,
  input  logic [7:0]  vga_x_out_bus,
  input  logic [7:0]  vga_y_out_bus,
  input  logic [23:0] vga_RGB_out_bus,
  input  logic        fb_ready,
  input  logic        clear_overflow,
  output logic [14:0] fb_address,
  output logic [23:0] fb_data,
  output logic        fb_wren,
  output logic [4:0]  level,
  output logic        busy,
  output logic        overflow
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [4:0]      LvlOne  = 5'd1;
  localparam logic [4:0]      LvlFull = 5'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StWrite} state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]      level_q, level_d;
  logic            overflow_q, overflow_d;
  logic [14:0]     fb_address_q;
  logic [23:0]     fb_data_q;

  // Entry layout: {x, y, rgb}
  logic [39:0] mem [DEPTH];
  logic [39:0] head;

  logic        in_range;
  logic        push_req;
  logic        push_accept;
  logic        ovf_set;
  logic        pop;
  logic        full;
  logic [14:0] head_x_ext;
  logic [14:0] head_y_ext;
  logic [14:0] head_addr;

  assign full = (level_q == LvlFull);
  assign head = mem[rd_ptr_q];

  always_comb begin
    in_range = ({24'd0, vga_x_out_bus} < SCREEN_W) && ({24'd0, vga_y_out_bus} < SCREEN_H);
    // A z/x enable takes the else path in 4-state simulation, so it never pushes.
    push_req = 1'b0;
    if (vga_draw_enable_bus == 1'b1) begin
      push_req = in_range;
    end
  end

  // A full FIFO still takes a push when the same edge pops the head.
  assign push_accept = push_req && (!full || pop);
  assign ovf_set     = push_req && full && !pop;

  // y*160 + x as shift-add; y < 120 keeps the result within 15 bits.
  assign head_x_ext = {7'd0, head[39:32]};
  assign head_y_ext = {7'd0, head[31:24]};
  assign head_addr  = (head_y_ext << 7) + (head_y_ext << 5) + head_x_ext;

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (level_q != 5'd0) begin
          state_d = StFetch;
        end
      end
      StFetch: begin
        if (level_q != 5'd0) begin
          pop     = 1'b1;
          state_d = StWrite;
        end else begin
          state_d = StIdle;
        end
      end
      StWrite: begin
        if (fb_ready) begin
          state_d = (level_q != 5'd0) ? StFetch : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_accept) begin
      wr_ptr_d = wr_ptr_q + PtrOne;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrOne;
    end
    unique case ({push_accept, pop})
      2'b10:   level_d = level_q + LvlOne;
      2'b01:   level_d = level_q - LvlOne;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      fb_address_q <= '0;
      fb_data_q    <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      if (pop) begin
        fb_address_q <= head_addr;
        fb_data_q    <= head[23:0];
      end
    end
  end

  // Storage has no reset; contents are only read behind a valid level.
  always_ff @(posedge clk) begin
    if (push_accept) begin
      mem[wr_ptr_q] <= {vga_x_out_bus, vga_y_out_bus, vga_RGB_out_bus};
    end
  end

  assign fb_address = fb_address_q;
  assign fb_data    = fb_data_q;
  assign fb_wren    = (state_q == StWrite);
  assign level      = level_q;
  assign busy       = (level_q != 5'd0) || (state_q != StIdle);
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Bench for pixel_write_buffer: transaction-level model checked every negedge, plus
// directed scenarios with hand-computed expectations.
module tb_pixel_write_buffer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [7:0]  xb;
  logic [7:0]  yb;
  logic [23:0] rgb;
  logic        fb_ready;
  logic        clear_overflow;
  logic [14:0] fb_address;
  logic [23:0] fb_data;
  logic        fb_wren;
  logic [4:0]  level;
  logic        busy;
  logic        overflow;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_write_buffer #(.DEPTH(DEPTH), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk                 (clk),
    .reset               (reset),
    .vga_draw_enable_bus (en),
    .vga_x_out_bus       (xb),
    .vga_y_out_bus       (yb),
    .vga_RGB_out_bus     (rgb),
    .fb_ready            (fb_ready),
    .clear_overflow      (clear_overflow),
    .fb_address          (fb_address),
    .fb_data             (fb_data),
    .fb_wren             (fb_wren),
    .level               (level),
    .busy                (busy),
    .overflow            (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int x;
    int y;
    int rgb;
  } pix_t;

  pix_t mq[$];
  pix_t m_wr;
  bit   m_wr_valid;
  bit   m_fetch;
  bit   m_ovf;

  always @(posedge clk or posedge reset) begin : model_step
    int   old_size;
    bit   do_pop;
    bit   do_push;
    bit   set_ovf;
    pix_t hd;
    pix_t np;
    if (reset) begin
      mq.delete();
      m_wr_valid = 0;
      m_fetch    = 0;
      m_ovf      = 0;
    end else begin
      old_size = mq.size();
      do_pop   = m_fetch && (old_size > 0);
      if (do_pop) hd = mq.pop_front();
      np.x    = int'(xb);
      np.y    = int'(yb);
      np.rgb  = int'(rgb);
      do_push = (en === 1'b1) && (np.x < 160) && (np.y < 120);
      set_ovf = 0;
      if (do_push) begin
        if (old_size < DEPTH || do_pop) mq.push_back(np);
        else set_ovf = 1;
      end
      if (set_ovf) m_ovf = 1;
      else if (clear_overflow === 1'b1) m_ovf = 0;
      if (do_pop) begin
        m_wr       = hd;
        m_wr_valid = 1;
        m_fetch    = 0;
      end else if (m_wr_valid) begin
        if (fb_ready === 1'b1) begin
          m_wr_valid = 0;
          m_fetch    = (old_size != 0);
        end
      end else if (!m_fetch && old_size != 0) begin
        m_fetch = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      chk("level", 40'(level), 40'(mq.size()));
      chk("fb_wren", 40'(fb_wren), 40'(m_wr_valid));
      if (m_wr_valid) begin
        chk("fb_address", 40'(fb_address), 40'(m_wr.y * 160 + m_wr.x));
        chk("fb_data", 40'(fb_data), 40'(m_wr.rgb));
      end
      chk("busy", 40'(busy), 40'(mq.size() != 0 || m_wr_valid || m_fetch));
      chk("overflow", 40'(overflow), 40'(m_ovf));
    end
  end

  // ---------------- observed write log ----------------
  logic [14:0] w_addr[$];
  logic [23:0] w_data[$];

  always @(posedge clk) begin
    if (reset === 1'b0 && fb_wren === 1'b1 && fb_ready === 1'b1) begin
      w_addr.push_back(fb_address);
      w_data.push_back(fb_data);
    end
  end

  function automatic logic [39:0] log_addr(input int i);
    if (i < w_addr.size()) return 40'(w_addr[i]);
    return 'x;
  endfunction

  function automatic logic [39:0] log_data(input int i);
    if (i < w_data.size()) return 40'(w_data[i]);
    return 'x;
  endfunction

  task automatic clear_log();
    w_addr.delete();
    w_data.delete();
  endtask

  task automatic px(input int x, input int y, input int c);
    en  = 1'b1;
    xb  = 8'(x);
    yb  = 8'(y);
    rgb = 24'(c);
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk("wait_idle_busy", 40'(busy), 40'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    en             = 1'b0;
    xb             = '0;
    yb             = '0;
    rgb            = '0;
    fb_ready       = 1'b0;
    clear_overflow = 1'b0;
    #12;
    chk("rst_fb_wren", 40'(fb_wren), 40'(0));
    chk("rst_level", 40'(level), 40'(0));
    chk("rst_busy", 40'(busy), 40'(0));
    chk("rst_overflow", 40'(overflow), 40'(0));
    chk("rst_fb_address", 40'(fb_address), 40'(0));
    chk("rst_fb_data", 40'(fb_data), 40'(0));
    reset = 1'b0;
    cycles(1);

    // Single pixel: wren appears two edges after the push.
    fb_ready = 1'b1;
    clear_log();
    px(5, 3, 24'hFF0000);
    chk("single_level", 40'(level), 40'(1));
    cycles(1);
    chk("single_fetch_wren", 40'(fb_wren), 40'(0));
    cycles(1);
    chk("single_wren", 40'(fb_wren), 40'(1));
    chk("single_addr", 40'(fb_address), 40'(485));
    chk("single_data", 40'(fb_data), 40'(24'hFF0000));
    wait_idle();
    chk("single_count", 40'(w_addr.size()), 40'(1));

    // Corners and off-screen rejects.
    clear_log();
    px(0, 0, 24'h123456);
    px(159, 119, 24'hABCDEF);
    px(160, 0, 24'h111111);
    px(0, 120, 24'h222222);
    wait_idle();
    chk("corner_count", 40'(w_addr.size()), 40'(2));
    chk("corner_addr0", log_addr(0), 40'(0));
    chk("corner_data0", log_data(0), 40'(24'h123456));
    chk("corner_addr1", log_addr(1), 40'(19199));
    chk("corner_data1", log_data(1), 40'(24'hABCDEF));
    chk("corner_overflow", 40'(overflow), 40'(0));

    // Backpressure: first write held stable for 10 cycles.
    fb_ready = 1'b0;
    clear_log();
    px(10, 20, 24'h010101);
    px(11, 21, 24'h020202);
    px(12, 22, 24'h030303);
    chk("bp_level", 40'(level), 40'(2));
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold_wren", 40'(fb_wren), 40'(1));
      chk("bp_hold_addr", 40'(fb_address), 40'(3210));
      chk("bp_hold_data", 40'(fb_data), 40'(24'h010101));
      cycles(1);
    end
    fb_ready = 1'b1;
    wait_idle();
    chk("bp_count", 40'(w_addr.size()), 40'(3));
    chk("bp_addr0", log_addr(0), 40'(3210));
    chk("bp_addr1", log_addr(1), 40'(3371));
    chk("bp_addr2", log_addr(2), 40'(3532));

    // Overflow: one pixel parked in the write stage, then 10 pushes against a stalled port.
    fb_ready = 1'b0;
    clear_log();
    px(1, 1, 24'hAA0000);
    cycles(2);
    for (int i = 0; i < 10; i++) px(20 + i, 50, 24'h100 + i);
    chk("ovf_level", 40'(level), 40'(8));
    chk("ovf_flag", 40'(overflow), 40'(1));
    fb_ready = 1'b1;
    wait_idle();
    chk("ovf_count", 40'(w_addr.size()), 40'(9));
    chk("ovf_first", log_addr(0), 40'(161));
    chk("ovf_last_addr", log_addr(8), 40'(8027));
    chk("ovf_last_data", log_data(8), 40'(24'h107));
    chk("ovf_sticky", 40'(overflow), 40'(1));
    clear_overflow = 1'b1;
    cycles(1);
    clear_overflow = 1'b0;
    chk("ovf_cleared", 40'(overflow), 40'(0));

    // Full FIFO with a push on the same edge as the fetch pop.
    fb_ready = 1'b0;
    clear_log();
    px(2, 2, 24'hBB0000);
    cycles(2);
    for (int i = 0; i < 8; i++) px(30 + i, 60, 24'h200 + i);
    chk("full_level", 40'(level), 40'(8));
    fb_ready = 1'b1;
    cycles(1);
    fb_ready = 1'b0;
    px(40, 61, 24'h2FF);
    chk("full_pop_level", 40'(level), 40'(8));
    chk("full_pop_overflow", 40'(overflow), 40'(0));
    fb_ready = 1'b1;
    wait_idle();
    chk("full_count", 40'(w_addr.size()), 40'(10));
    chk("full_last_addr", log_addr(9), 40'(9800));
    chk("full_last_data", log_data(9), 40'(24'h2FF));

    // Asynchronous reset while a write is pending.
    fb_ready = 1'b0;
    px(3, 3, 24'hCC0000);
    cycles(2);
    for (int i = 0; i < 4; i++) px(50 + i, 70, 24'h300 + i);
    chk("arst_pre_level", 40'(level), 40'(4));
    chk("arst_pre_wren", 40'(fb_wren), 40'(1));
    #3;
    reset = 1'b1;
    #1;
    chk("arst_wren", 40'(fb_wren), 40'(0));
    chk("arst_level", 40'(level), 40'(0));
    chk("arst_busy", 40'(busy), 40'(0));
    #1;
    reset = 1'b0;
    clear_log();
    fb_ready = 1'b1;
    cycles(10);
    chk("arst_no_writes", 40'(w_addr.size()), 40'(0));
    chk("arst_idle", 40'(busy), 40'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
